wombat_command_initiator: RTL and testbench
===========================================

// Module: wombat_command_initiator
// PURPOSE
//  Host-side initiator for the wombat UART register protocol; counterpart of wombat_command_parser_uart.
//  Takes one register read/write request and serialises it as six bytes into a uart_tx byte interface:
//    cmd, addr, value[31:24], value[23:16], value[15:8], value[7:0].
//  For reads, it collects the 4-byte reply (MSB first) from a uart_rx byte interface.
//  Used in benches and FPGA loopback to drive the parser + register_block without a PC.
// PARAMETERS
//  WORD_WIDTH  8       byte width of the serial link (bits)
//  REG_WIDTH   4       value width in bytes; value = WORD_WIDTH*REG_WIDTH bits
//  READ_CMD    8'h72   command byte for read ('r')
//  WRITE_CMD   8'h77   command byte for write ('w')
//  TIMEOUT     200000  clk cycles allowed between read-reply bytes (and before the first one)
// PORTS
//  clk          in   1                     system clock
//  i_reset      in   1                     synchronous active-high reset
//  i_req_valid  in   1                     request present
//  o_req_ready  out  1                     high only in IDLE; request accepted when valid&&ready
//  i_req_write  in   1                     1=write, 0=read
//  i_req_addr   in   WORD_WIDTH            register address
//  i_req_value  in   WORD_WIDTH*REG_WIDTH  write value (ignored for read; zeros are sent)
//  o_tx_data    out  WORD_WIDTH            byte to uart_tx i_data
//  o_tx_dv      out  1                     one-cycle strobe to uart_tx i_dv
//  i_tx_busy    in   1                     uart_tx o_busy
//  i_rx_data    in   WORD_WIDTH            byte from uart_rx o_data
//  i_rx_dv      in   1                     uart_rx o_data_valid (one-cycle)
//  o_done       out  1                     one-cycle pulse: transaction finished (write or read, ok or timeout)
//  o_timeout    out  1                     valid with o_done: read reply timed out
//  o_rsp_value  out  WORD_WIDTH*REG_WIDTH  read data; updated only on a successful read
// BEHAVIOUR
//  Reset: state=IDLE; o_req_ready=1; o_tx_dv=0; o_tx_data=0; o_done=0; o_timeout=0; o_rsp_value=0.
//    Reset mid-transaction aborts immediately; no o_done is issued; partial reply is discarded.
//  Accept: on valid&&ready, latch write flag, addr and value (read latches value=0).
//    Build a (2+REG_WIDTH)-byte shift register and go to TX_BYTE. Later input changes are ignored.
//  FSM:
//    IDLE -> TX_BYTE on accept.
//    TX_BYTE: drive o_tx_data = current byte, o_tx_dv=1 for exactly one cycle; byte_cnt++ -> TX_GAP.
//    TX_GAP: 2 cycles, i_tx_busy ignored (covers uart_tx busy latency) -> TX_WAIT.
//    TX_WAIT: wait for i_tx_busy==0. If more bytes remain -> TX_BYTE.
//      Last byte sent on a write -> DONE. Last byte sent on a read -> RX_WAIT.
//    RX_WAIT: on i_rx_dv, shift i_rx_data into the LSB of the accumulator
//      (first byte ends in the MSB); rx_cnt++; timer cleared.
//      After REG_WIDTH bytes: o_rsp_value <= accumulator -> DONE.
//      Timer counts every cycle without i_rx_dv; when it reaches TIMEOUT -> DONE with
//      o_timeout=1, o_rsp_value unchanged.
//    DONE: o_done=1 for one cycle (o_timeout=1 only on timeout, else 0) -> IDLE.
//  o_done and o_timeout are 0 in every state other than DONE.
//  Latency, write: accept to o_done = 6 byte slots + 1 cycle. Back-to-back requests are allowed:
//    next accept at the earliest in the cycle after DONE.
//  i_rx_dv outside RX_WAIT is discarded: it does not affect rx_cnt, timer or o_rsp_value.
//  Surplus reply bytes after completion are dropped.
//  i_rx_dv in the same cycle the timer hits TIMEOUT: the byte wins and the timer clears.
//  Byte/counter widths: byte_cnt is $clog2(REG_WIDTH+2)+1 bits; timer is $clog2(TIMEOUT+1) bits, saturating.
// TESTING
//  Loopback through uart_tx -> wombat_command_parser_uart -> register_block -> uart_rx.
//  1 Write addr 8'h03, value 32'hDEADBEEF -> tx bytes 77,03,DE,AD,BE,EF in order;
//    reg[3]==DEADBEEF; one o_done, o_timeout=0.
//  2 After test 1, read addr 8'h03 -> tx 72,03,00,00,00,00;
//    o_rsp_value==32'hDEADBEEF with o_done, o_timeout=0.
//  3 Read with rx held idle (parser disconnected), TIMEOUT=1000
//    -> o_done+o_timeout exactly 1000 cycles after the 6th byte completes; o_rsp_value unchanged.
//  4 Inject rx bytes 12,34 in IDLE, then read with reply 12,34,56,78 -> o_rsp_value==32'h12345678.
//  5 Hold i_req_valid during a write -> o_req_ready=0 until after o_done; a second request is then
//    accepted; writes 16 regs, addr=i, value={lfsr,i}, and reads each back to match.
//  6 Assert i_reset during the 3rd tx byte -> o_tx_dv stops, no o_done, o_req_ready=1 next cycle;
//    a following write completes normally.

Source files
------------

// File: rtl/wombat_command_initiator.sv
// Host-side initiator for the wombat UART register protocol. Serialises one register
// read/write request as cmd, addr, value (MSB first) into a uart_tx byte interface and,
// for reads, collects the REG_WIDTH-byte reply from a uart_rx byte interface.
module wombat_command_initiator #(
   parameter int unsigned           WORD_WIDTH = 8,
   parameter int unsigned           REG_WIDTH  = 4,
   parameter logic [WORD_WIDTH-1:0] READ_CMD   = 8'h72,
   parameter logic [WORD_WIDTH-1:0] WRITE_CMD  = 8'h77,
   parameter int unsigned           TIMEOUT    = 200000
) (
   input  logic                             clk,
   input  logic                             i_reset,
   input  logic                             i_req_valid,
   output logic                             o_req_ready,
   input  logic                             i_req_write,
   input  logic [WORD_WIDTH-1:0]            i_req_addr,
   input  logic [WORD_WIDTH*REG_WIDTH-1:0]  i_req_value,
   output logic [WORD_WIDTH-1:0]            o_tx_data,
   output logic                             o_tx_dv,
   input  logic                             i_tx_busy,
   input  logic [WORD_WIDTH-1:0]            i_rx_data,
   input  logic                             i_rx_dv,
   output logic                             o_done,
   output logic                             o_timeout,
   output logic [WORD_WIDTH*REG_WIDTH-1:0]  o_rsp_value
);

   localparam int unsigned ValW     = WORD_WIDTH * REG_WIDTH;
   localparam int unsigned FrameW   = WORD_WIDTH * (REG_WIDTH + 2);
   localparam int unsigned ByteCntW = $clog2(REG_WIDTH + 2) + 1;
   localparam int unsigned RxCntW   = $clog2(REG_WIDTH + 1);
   localparam int unsigned TimerW   = $clog2(TIMEOUT + 1);

   localparam logic [ByteCntW-1:0] NumBytes   = ByteCntW'(REG_WIDTH + 2);
   localparam logic [RxCntW-1:0]   LastRx     = RxCntW'(REG_WIDTH - 1);
   localparam logic [TimerW-1:0]   TimeoutVal = TimerW'(TIMEOUT);

   typedef enum logic [2:0] {
      StIdle,
      StTxByte,
      StTxGap,
      StTxWait,
      StRxWait,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic                write_q, write_d;
   logic [FrameW-1:0]   frame_q, frame_d;
   logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
   logic                gap_q, gap_d;
   logic [RxCntW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [ValW-1:0]     acc_q, acc_d;
   logic [ValW-1:0]     rsp_q, rsp_d;
   logic                timeout_q, timeout_d;

   logic [ValW-1:0]       req_value;
   logic [WORD_WIDTH-1:0] req_cmd;

   // Reads carry an all-zero value field on the wire.
   assign req_value   = i_req_write ? i_req_value : '0;
   assign req_cmd     = i_req_write ? WRITE_CMD : READ_CMD;
   assign o_rsp_value = rsp_q;

   // Next-state, datapath updates and strobes for the transaction sequencer.
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      frame_d     = frame_q;
      byte_cnt_d  = byte_cnt_q;
      gap_d       = gap_q;
      rx_cnt_d    = rx_cnt_q;
      timer_d     = timer_q;
      acc_d       = acc_q;
      rsp_d       = rsp_q;
      timeout_d   = timeout_q;
      o_req_ready = 1'b0;
      o_tx_dv     = 1'b0;
      o_tx_data   = '0;
      o_done      = 1'b0;
      o_timeout   = 1'b0;

      case (state_q)
         StIdle: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               write_d    = i_req_write;
               frame_d    = {req_cmd, i_req_addr, req_value};
               byte_cnt_d = '0;
               timeout_d  = 1'b0;
               state_d    = StTxByte;
            end
         end
         StTxByte: begin
            o_tx_dv    = 1'b1;
            o_tx_data  = frame_q[FrameW-1 -: WORD_WIDTH];
            frame_d    = frame_q << WORD_WIDTH;
            byte_cnt_d = byte_cnt_q + 1'b1;
            gap_d      = 1'b0;
            state_d    = StTxGap;
         end
         // uart_tx raises busy a cycle or two after dv, so busy is not trusted here.
         StTxGap: begin
            if (gap_q) begin
               state_d = StTxWait;
            end else begin
               gap_d = 1'b1;
            end
         end
         StTxWait: begin
            if (!i_tx_busy) begin
               if (byte_cnt_q != NumBytes) begin
                  state_d = StTxByte;
               end else if (write_q) begin
                  state_d = StDone;
               end else begin
                  rx_cnt_d = '0;
                  timer_d  = '0;
                  acc_d    = '0;
                  state_d  = StRxWait;
               end
            end
         end
         StRxWait: begin
            if (i_rx_dv) begin
               // A byte arriving on the would-be timeout cycle takes priority.
               acc_d    = (acc_q << WORD_WIDTH) | ValW'(i_rx_data);
               rx_cnt_d = rx_cnt_q + 1'b1;
               timer_d  = '0;
               if (rx_cnt_q == LastRx) begin
                  rsp_d   = acc_d;
                  state_d = StDone;
               end
            end else begin
               if (timer_q != TimeoutVal) begin
                  timer_d = timer_q + 1'b1;
               end
               if (timer_d == TimeoutVal) begin
                  timeout_d = 1'b1;
                  state_d   = StDone;
               end
            end
         end
         StDone: begin
            o_done    = 1'b1;
            o_timeout = timeout_q;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q    <= StIdle;
         write_q    <= 1'b0;
         frame_q    <= '0;
         byte_cnt_q <= '0;
         gap_q      <= 1'b0;
         rx_cnt_q   <= '0;
         timer_q    <= '0;
         acc_q      <= '0;
         rsp_q      <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         frame_q    <= frame_d;
         byte_cnt_q <= byte_cnt_d;
         gap_q      <= gap_d;
         rx_cnt_q   <= rx_cnt_d;
         timer_q    <= timer_d;
         acc_q      <= acc_d;
         rsp_q      <= rsp_d;
         timeout_q  <= timeout_d;
      end
   end

endmodule

// File: tb/tb_wombat_command_initiator.sv
// Directed bench for wombat_command_initiator. A far-end model stands in for
// uart_tx/parser/register_block/uart_rx: it holds busy for BUSY_CYC cycles per byte,
// stores write frames and answers read frames with one reply byte every 3 cycles.
// Timing with BUSY_CYC=5: each byte slot is 6 cycles (dv, 2 gap, 3 wait), so the first
// TX_BYTE is k=1, the 6th is k=31 and a write shows o_done at k=37. A read reply lands
// at k6+7,+10,+13,+16 giving o_done at k=48. With TIMEOUT=1000 the receive phase starts
// 6 cycles after the 6th dv and times out 1000 cycles later: o_done at k6+1006.
module tb_wombat_command_initiator;

   localparam int unsigned TMO      = 1000;
   localparam int          BUSY_CYC = 5;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_write;
   logic [7:0]  i_req_addr;
   logic [31:0] i_req_value;
   logic [7:0]  o_tx_data;
   logic        o_tx_dv;
   logic        i_tx_busy;
   logic [7:0]  i_rx_data;
   logic        i_rx_dv;
   logic        o_done;
   logic        o_timeout;
   logic [31:0] o_rsp_value;

   wombat_command_initiator #(
      .WORD_WIDTH (8),
      .REG_WIDTH  (4),
      .READ_CMD   (8'h72),
      .WRITE_CMD  (8'h77),
      .TIMEOUT    (TMO)
   ) dut (
      .clk         (clk),
      .i_reset     (i_reset),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_write (i_req_write),
      .i_req_addr  (i_req_addr),
      .i_req_value (i_req_value),
      .o_tx_data   (o_tx_data),
      .o_tx_dv     (o_tx_dv),
      .i_tx_busy   (i_tx_busy),
      .i_rx_data   (i_rx_data),
      .i_rx_dv     (i_rx_dv),
      .o_done      (o_done),
      .o_timeout   (o_timeout),
      .o_rsp_value (o_rsp_value)
   );

   always #5 clk = ~clk;

   int          pass_cnt = 0;
   int          chk_cnt  = 0;
   bit          link_en  = 1'b1;
   logic [31:0] far_regs [256];
   logic [7:0]  rx_q [$];
   logic [7:0]  fr [$];
   logic [7:0]  tx_seen [6];
   int          ntx;

   // Far-end model: tx busy, register store and read replies.
   initial begin : far_end
      int          busy_left;
      int          rx_gap;
      logic [31:0] rd;
      busy_left = 0;
      rx_gap    = 0;
      i_tx_busy = 1'b0;
      i_rx_dv   = 1'b0;
      i_rx_data = 8'h00;
      for (int a = 0; a < 256; a++) far_regs[a] = 32'h0;
      forever begin
         @(posedge clk); #1;
         i_rx_dv = 1'b0;
         if (i_reset) fr.delete();
         if (busy_left > 0) busy_left--;
         if (o_tx_dv) begin
            busy_left = BUSY_CYC;
            if (link_en) fr.push_back(o_tx_data);
         end
         i_tx_busy = (busy_left > 0);
         if (fr.size() == 6 && busy_left == 0) begin
            if (fr[0] == 8'h77) begin
               far_regs[fr[1]] = {fr[2], fr[3], fr[4], fr[5]};
            end else if (fr[0] == 8'h72) begin
               rd = far_regs[fr[1]];
               rx_q.push_back(rd[31:24]);
               rx_q.push_back(rd[23:16]);
               rx_q.push_back(rd[15:8]);
               rx_q.push_back(rd[7:0]);
               rx_gap = 2;
            end
            fr.delete();
         end
         if (rx_gap > 0) begin
            rx_gap--;
         end else if (rx_q.size() > 0) begin
            i_rx_dv   = 1'b1;
            i_rx_data = rx_q.pop_front();
            rx_gap    = 2;
         end
      end
   end

   // Issue one request and follow it to o_done; k counts cycles from the first TX_BYTE (k=1).
   task automatic run_req(input logic wr, input logic [7:0] addr, input logic [31:0] val,
                          output bit got_done, output logic tmo, output int done_k,
                          output int k6);
      int n;
      n        = 0;
      ntx      = 0;
      got_done = 1'b0;
      tmo      = 1'bx;
      done_k   = -1;
      k6       = -1;
      i_req_valid = 1'b1;
      i_req_write = wr;
      i_req_addr  = addr;
      i_req_value = val;
      while (!o_req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      // Scramble the request lines; the latched copy must be used.
      i_req_valid = 1'b0;
      i_req_write = ~wr;
      i_req_addr  = 8'hFF;
      i_req_value = 32'hFFFF_FFFF;
      for (int k = 1; k <= 3000; k++) begin
         if (o_tx_dv) begin
            if (ntx < 6) tx_seen[ntx] = o_tx_data;
            ntx++;
            if (ntx == 6) k6 = k;
         end
         if (o_done) begin
            got_done = 1'b1;
            tmo      = o_timeout;
            done_k   = k;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      i_reset     = 1'b1;
      i_req_valid = 1'b0;
      i_req_write = 1'b0;
      i_req_addr  = 8'h00;
      i_req_value = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++; if (o_req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", o_req_ready); else pass_cnt++;
      chk_cnt++; if (o_tx_dv !== 1'b0) $display("FAIL rst_tx_dv: got %b want 0", o_tx_dv); else pass_cnt++;
      chk_cnt++; if (o_tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", o_tx_data); else pass_cnt++;
      chk_cnt++; if (o_done !== 1'b0) $display("FAIL rst_done: got %b want 0", o_done); else pass_cnt++;
      chk_cnt++; if (o_timeout !== 1'b0) $display("FAIL rst_timeout: got %b want 0", o_timeout); else pass_cnt++;
      chk_cnt++; if (o_rsp_value !== 32'h0) $display("FAIL rst_rsp: got %h want 0", o_rsp_value); else pass_cnt++;
      i_reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      bit         gd;
      logic       tmo;
      int         dk;
      int         k6;
      logic [7:0] exp_tx [6];
      exp_tx = '{8'h77, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_req(1'b1, 8'h03, 32'hDEADBEEF, gd, tmo, dk, k6);
      chk_cnt++; if (gd !== 1'b1) $display("FAIL wr_done: got %b want 1", gd); else pass_cnt++;
      chk_cnt++; if (tmo !== 1'b0) $display("FAIL wr_timeout: got %b want 0", tmo); else pass_cnt++;
      chk_cnt++; if (ntx !== 6) $display("FAIL wr_ntx: got %0d want 6", ntx); else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         chk_cnt++;
         if (tx_seen[i] !== exp_tx[i]) $display("FAIL wr_byte%0d: got %h want %h", i, tx_seen[i], exp_tx[i]);
         else pass_cnt++;
      end
      chk_cnt++; if (k6 !== 31) $display("FAIL wr_k6: got %0d want 31", k6); else pass_cnt++;
      chk_cnt++; if (dk !== 37) $display("FAIL wr_latency: got %0d want 37", dk); else pass_cnt++;
      chk_cnt++; if (far_regs[3] !== 32'hDEADBEEF) $display("FAIL wr_reg3: got %h want deadbeef", far_regs[3]); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (o_done !== 1'b0) $display("FAIL wr_done_pulse: got %b want 0", o_done); else pass_cnt++;
   endtask

   task automatic test_read();
      bit         gd;
      logic       tmo;
      int         dk;
      int         k6;
      logic [7:0] exp_tx [6];
      exp_tx = '{8'h72, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
      run_req(1'b0, 8'h03, 32'h5555_AAAA, gd, tmo, dk, k6);
      chk_cnt++; if (gd !== 1'b1) $display("FAIL rd_done: got %b want 1", gd); else pass_cnt++;
      chk_cnt++; if (tmo !== 1'b0) $display("FAIL rd_timeout: got %b want 0", tmo); else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         chk_cnt++;
         if (tx_seen[i] !== exp_tx[i]) $display("FAIL rd_byte%0d: got %h want %h", i, tx_seen[i], exp_tx[i]);
         else pass_cnt++;
      end
      chk_cnt++; if (o_rsp_value !== 32'hDEADBEEF) $display("FAIL rd_rsp: got %h want deadbeef", o_rsp_value); else pass_cnt++;
      chk_cnt++; if (dk !== 48) $display("FAIL rd_latency: got %0d want 48", dk); else pass_cnt++;
   endtask

   task automatic test_timeout();
      bit   gd;
      logic tmo;
      int   dk;
      int   k6;
      link_en = 1'b0;
      run_req(1'b0, 8'h05, 32'h0, gd, tmo, dk, k6);
      chk_cnt++; if (gd !== 1'b1) $display("FAIL tmo_done: got %b want 1", gd); else pass_cnt++;
      chk_cnt++; if (tmo !== 1'b1) $display("FAIL tmo_flag: got %b want 1", tmo); else pass_cnt++;
      chk_cnt++; if (dk - k6 !== 1006) $display("FAIL tmo_cycles: got %0d want 1006", dk - k6); else pass_cnt++;
      chk_cnt++; if (o_rsp_value !== 32'hDEADBEEF) $display("FAIL tmo_rsp: got %h want deadbeef", o_rsp_value); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (o_timeout !== 1'b0) $display("FAIL tmo_clear: got %b want 0", o_timeout); else pass_cnt++;
      link_en = 1'b1;
   endtask

   task automatic test_stray_rx();
      bit   gd;
      logic tmo;
      int   dk;
      int   k6;
      int   ndone;
      ndone = 0;
      rx_q.push_back(8'h12);
      rx_q.push_back(8'h34);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (o_done) ndone++;
      end
      chk_cnt++; if (ndone !== 0) $display("FAIL idle_rx_done: got %0d want 0", ndone); else pass_cnt++;
      chk_cnt++; if (o_rsp_value !== 32'hDEADBEEF) $display("FAIL idle_rx_rsp: got %h want deadbeef", o_rsp_value); else pass_cnt++;
      far_regs[8'h20] = 32'h12345678;
      run_req(1'b0, 8'h20, 32'h0, gd, tmo, dk, k6);
      chk_cnt++; if (gd !== 1'b1) $display("FAIL inj_done: got %b want 1", gd); else pass_cnt++;
      chk_cnt++; if (o_rsp_value !== 32'h12345678) $display("FAIL inj_rsp: got %h want 12345678", o_rsp_value); else pass_cnt++;
      // Surplus bytes after completion must be dropped.
      rx_q.push_back(8'h9A);
      rx_q.push_back(8'hBC);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (o_done) ndone++;
      end
      chk_cnt++; if (ndone !== 0) $display("FAIL surplus_done: got %0d want 0", ndone); else pass_cnt++;
      chk_cnt++; if (o_rsp_value !== 32'h12345678) $display("FAIL surplus_rsp: got %h want 12345678", o_rsp_value); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int          ready_bad;
      int          dk;
      int          n;
      bit          gd;
      logic        tmo;
      int          k6;
      logic [23:0] lfsr;
      logic [31:0] expv [16];
      ready_bad = 0;
      dk        = -1;
      n         = 0;
      i_req_valid = 1'b1;
      i_req_write = 1'b1;
      i_req_addr  = 8'h10;
      i_req_value = 32'h0BAD_F00D;
      while (!o_req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      for (int k = 1; k <= 200; k++) begin
         if (o_done) begin
            dk = k;
            break;
         end
         if (o_req_ready) ready_bad++;
         @(posedge clk); #1;
      end
      // Valid stays high; the second request is presented during DONE.
      i_req_addr  = 8'h11;
      i_req_value = 32'h1234_5678;
      chk_cnt++; if (ready_bad !== 0) $display("FAIL b2b_ready_busy: got %0d want 0", ready_bad); else pass_cnt++;
      chk_cnt++; if (dk !== 37) $display("FAIL b2b_first_latency: got %0d want 37", dk); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (o_req_ready !== 1'b1) $display("FAIL b2b_ready_idle: got %b want 1", o_req_ready); else pass_cnt++;
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      chk_cnt++; if (o_tx_dv !== 1'b1 || o_tx_data !== 8'h77) $display("FAIL b2b_second_start: got dv=%b data=%h want dv=1 data=77", o_tx_dv, o_tx_data); else pass_cnt++;
      dk = -1;
      for (int k = 1; k <= 200; k++) begin
         if (o_done) begin
            dk = k;
            break;
         end
         @(posedge clk); #1;
      end
      chk_cnt++; if (dk !== 37) $display("FAIL b2b_second_latency: got %0d want 37", dk); else pass_cnt++;
      chk_cnt++; if (far_regs[8'h10] !== 32'h0BAD_F00D) $display("FAIL b2b_reg10: got %h want 0badf00d", far_regs[8'h10]); else pass_cnt++;
      chk_cnt++; if (far_regs[8'h11] !== 32'h1234_5678) $display("FAIL b2b_reg11: got %h want 12345678", far_regs[8'h11]); else pass_cnt++;
      // Sixteen writes of {lfsr, i} followed by readback.
      lfsr = 24'hACE1_23;
      for (int i = 0; i < 16; i++) begin
         expv[i] = {lfsr, 8'(i)};
         run_req(1'b1, 8'(i), expv[i], gd, tmo, dk, k6);
         lfsr = {lfsr[22:0], lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};
      end
      for (int i = 0; i < 16; i++) begin
         run_req(1'b0, 8'(i), 32'h0, gd, tmo, dk, k6);
         chk_cnt++;
         if (gd !== 1'b1 || o_rsp_value !== expv[i])
            $display("FAIL lfsr_rd%0d: got done=%b rsp=%h want done=1 rsp=%h", i, gd, o_rsp_value, expv[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      int          n;
      int          nbad;
      bit          gd;
      logic        tmo;
      int          dk;
      int          k6;
      logic [7:0]  exp_tx [6];
      exp_tx = '{8'h77, 8'h30, 8'h01, 8'h02, 8'h03, 8'h04};
      n    = 0;
      nbad = 0;
      ntx  = 0;
      i_req_valid = 1'b1;
      i_req_write = 1'b1;
      i_req_addr  = 8'h30;
      i_req_value = 32'hCAFE_F00D;
      while (!o_req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      n = 0;
      while (n < 200) begin
         if (o_tx_dv) ntx++;
         if (ntx == 3) break;
         @(posedge clk); #1;
         n++;
      end
      chk_cnt++; if (ntx !== 3) $display("FAIL rmid_third_byte: got %0d want 3", ntx); else pass_cnt++;
      i_reset = 1'b1;
      @(posedge clk); #1;
      chk_cnt++; if (o_tx_dv !== 1'b0) $display("FAIL rmid_tx_dv: got %b want 0", o_tx_dv); else pass_cnt++;
      chk_cnt++; if (o_req_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", o_req_ready); else pass_cnt++;
      chk_cnt++; if (o_rsp_value !== 32'h0) $display("FAIL rmid_rsp: got %h want 0", o_rsp_value); else pass_cnt++;
      @(posedge clk); #1;
      i_reset = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (o_done || o_tx_dv) nbad++;
         @(posedge clk); #1;
      end
      chk_cnt++; if (nbad !== 0) $display("FAIL rmid_quiet: got %0d want 0", nbad); else pass_cnt++;
      chk_cnt++; if (far_regs[8'h30] !== 32'h0) $display("FAIL rmid_reg30: got %h want 0", far_regs[8'h30]); else pass_cnt++;
      run_req(1'b1, 8'h30, 32'h0102_0304, gd, tmo, dk, k6);
      chk_cnt++; if (gd !== 1'b1 || tmo !== 1'b0) $display("FAIL rmid_next_done: got done=%b tmo=%b want 1/0", gd, tmo); else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         chk_cnt++;
         if (tx_seen[i] !== exp_tx[i]) $display("FAIL rmid_byte%0d: got %h want %h", i, tx_seen[i], exp_tx[i]);
         else pass_cnt++;
      end
      chk_cnt++; if (far_regs[8'h30] !== 32'h0102_0304) $display("FAIL rmid_reg30_after: got %h want 01020304", far_regs[8'h30]); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_stray_rx();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
